// File: rtl/int_gen_if.sv
// Bus bundle between the bridge (master) and the interrupt generator (slave).
interface int_gen_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        IRQ;

  modport master (output addr, byteen, wdata, input rdata, IRQ);
  modport slave  (input addr, byteen, wdata, output rdata, IRQ);
endinterface

// File: rtl/int_gen.sv
// Memory-mapped programmable down-counter interrupt source with software ACK.
// Optional ACK counter in STATUS[31:16] is enabled by defining INT_GEN_ACKCNT_EN.
module int_gen #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
  input  logic     clk,
  input  logic     reset,
  int_gen_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CNT, S_PND} state_t;

  state_t      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] period_q, period_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;

  logic [29:0] woff;
  logic        in_win, wr_hit;
  logic        ctrl_wr, period_wr, status_wr, ack_wr;
  logic [2:0]  ctrl_merged;
  logic [31:0] period_merged;
  logic        start, stop, expire, reload;
  logic [15:0] status_hi;
  logic        unused_addr_lsb;

  // Word offset; addresses below the base wrap to large values and miss the window.
  assign woff      = bus.addr[31:2] - BASE_ADDR[31:2];
  assign in_win    = (woff < 30'd5);
  assign wr_hit    = in_win && (bus.byteen != 4'b0000);
  assign ctrl_wr   = wr_hit && (woff == 30'd0);
  assign period_wr = wr_hit && (woff == 30'd1);
  assign status_wr = wr_hit && (woff == 30'd3);
  assign ack_wr    = wr_hit && (woff == 30'd4);
  assign unused_addr_lsb = ^bus.addr[1:0];

  always_comb begin
    ctrl_merged = bus.byteen[0] ? bus.wdata[2:0] : ctrl_q;
    period_merged = period_q;
    for (int i = 0; i < 4; i++) begin
      if (bus.byteen[i]) period_merged[8*i +: 8] = bus.wdata[8*i +: 8];
    end
  end

  assign start  = (state_q == S_IDLE) && ctrl_wr && !ctrl_q[0] && ctrl_merged[0];
  assign stop   = ctrl_wr && !ctrl_merged[0];
  assign expire = (state_q == S_CNT) && (count_q == 32'd0) && !stop;
  assign reload = ctrl_q[1] && ctrl_q[0];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CNT;
      S_CNT:   if (count_q == 32'd0) state_d = S_PND;
      S_PND:   if (ack_wr) state_d = reload ? S_CNT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (stop) state_d = S_IDLE;
  end

  always_comb begin
    ctrl_d   = ctrl_wr ? ctrl_merged : ctrl_q;
    period_d = period_wr ? period_merged : period_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: if (start) count_d = period_q;
      S_CNT:  if (count_q != 32'd0 && !stop) count_d = count_q - 32'd1;
      S_PND: begin
        if (ack_wr && reload) count_d = period_q;
        if (ack_wr && !reload) ctrl_d[0] = 1'b0;
      end
      default: count_d = count_q;
    endcase
    // Expiry wins over a coincident ACK so no interrupt is lost.
    pend_d = pend_q;
    if (expire)      pend_d = 1'b1;
    else if (ack_wr) pend_d = 1'b0;
    irq_d = pend_d & ctrl_d[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= 3'b000;
      period_q <= 32'd0;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end

`ifdef INT_GEN_ACKCNT_EN
  logic [15:0] ackcnt_q, ackcnt_d;

  always_comb begin
    ackcnt_d = ackcnt_q;
    if (status_wr) ackcnt_d = 16'd0;
    else if (ack_wr && pend_q && !expire && ackcnt_q != 16'hFFFF) ackcnt_d = ackcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) ackcnt_q <= 16'd0;
    else       ackcnt_q <= ackcnt_d;
  end

  assign status_hi = ackcnt_q;
`else
  logic unused_status_wr;
  assign unused_status_wr = status_wr;
  assign status_hi = 16'd0;
`endif

  always_comb begin
    bus.rdata = 32'd0;
    if (in_win) begin
      case (woff)
        30'd0:   bus.rdata = {29'd0, ctrl_q};
        30'd1:   bus.rdata = period_q;
        30'd2:   bus.rdata = count_q;
        30'd3:   bus.rdata = {status_hi, 15'd0, pend_q};
        default: bus.rdata = 32'd0;
      endcase
    end
  end

  assign bus.IRQ = irq_q;

endmodule

// File: tb/tb_int_gen.sv
// Directed bench for int_gen: stimulus queues expectations, a negedge monitor checks them.
module tb_int_gen;

  localparam logic [31:0] BASE = 32'h0000_7F20;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PER  = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;
  localparam logic [31:0] A_STS  = BASE + 32'hC;
  localparam logic [31:0] A_ACK  = BASE + 32'h10;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic chk_vld;
  int   total = 0;
  int   bad = 0;
  logic [15:0] acks = 16'd0;
  exp_t sbq[$];

  int_gen_if bus ();

  int_gen #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_vld) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: check strobe with no expectation queued");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        total += 2;
        if (bus.rdata !== e.rd) begin
          bad++;
          $display("FAIL %s rdata got=%h want=%h", e.name, bus.rdata, e.rd);
        end
        if (bus.IRQ !== e.irq) begin
          bad++;
          $display("FAIL %s irq got=%b want=%b", e.name, bus.IRQ, e.irq);
        end
      end
    end
  end

  function automatic logic [31:0] st(input logic p);
`ifdef INT_GEN_ACKCNT_EN
    return {acks, 15'd0, p};
`else
    return {31'd0, p};
`endif
  endfunction

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.addr = a;
    bus.byteen = be;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.byteen = 4'b0000;
  endtask

  task automatic chk(input logic [31:0] a, input logic [31:0] rd, input logic irq, input string nm);
    exp_t e;
    e.name = nm;
    e.rd = rd;
    e.irq = irq;
    sbq.push_back(e);
    bus.addr = a;
    bus.byteen = 4'b0000;
    chk_vld = 1'b1;
    @(posedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    chk_vld = 1'b0;
    bus.addr = 32'd0;
    bus.byteen = 4'b0000;
    bus.wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk(A_CTRL, 32'd0, 1'b0, "rst_ctrl");
    chk(A_PER,  32'd0, 1'b0, "rst_period");
    chk(A_CNT,  32'd0, 1'b0, "rst_count");
    chk(A_STS,  32'd0, 1'b0, "rst_status");

    // One-shot: PERIOD 5, IRQ after enable edge + 6
    wr(A_PER, 4'hF, 32'd5);
    wr(A_CTRL, 4'hF, 32'h5);
    for (int i = 0; i < 6; i++) chk(A_CNT, 32'(5 - i), 1'b0, "oneshot_count");
    chk(A_CNT, 32'd0, 1'b1, "oneshot_irq");
    wr(A_ACK, 4'hF, 32'd1);
    acks++;
    chk(A_CTRL, 32'h4, 1'b0, "oneshot_ack_ctrl");
    chk(A_STS, st(1'b0), 1'b0, "oneshot_ack_status");

    // Periodic: PERIOD 3, IRQ four edges after enable and after each ACK
    wr(A_PER, 4'hF, 32'd3);
    wr(A_CTRL, 4'hF, 32'h7);
    for (int i = 0; i < 4; i++) chk(A_STS, st(1'b0), 1'b0, "per_wait0");
    chk(A_STS, st(1'b1), 1'b1, "per_irq0");
    for (int r = 0; r < 3; r++) begin
      wr(A_ACK, 4'hF, 32'd1);
      acks++;
      for (int i = 0; i < 4; i++) chk(A_STS, st(1'b0), 1'b0, "per_wait");
      chk(A_STS, st(1'b1), 1'b1, "per_irq");
    end
    wr(A_CTRL, 4'hF, 32'h0);
    chk(A_STS, st(1'b1), 1'b0, "disable_keeps_pend");
    wr(A_ACK, 4'hF, 32'd1);
    acks++;
    chk(A_STS, st(1'b0), 1'b0, "disable_ack");

    // Masking, then unmask through lane 0 only
    wr(A_PER, 4'hF, 32'd0);
    wr(A_CTRL, 4'hF, 32'h1);
    chk(A_STS, st(1'b0), 1'b0, "mask_cnt");
    chk(A_STS, st(1'b1), 1'b0, "mask_pend_noirq");
    wr(A_CTRL, 4'b0001, 32'h5);
    chk(A_STS, st(1'b1), 1'b1, "unmask_irq");
    chk(A_CTRL, 32'h5, 1'b1, "unmask_ctrl");
    wr(A_ACK, 4'hF, 32'd1);
    acks++;
    chk(A_CTRL, 32'h4, 1'b0, "mask_ack_ctrl");

    // Collision: second ACK lands on the expiry edge of a PERIOD 0 reload
    wr(A_CTRL, 4'hF, 32'h7);
    chk(A_STS, st(1'b0), 1'b0, "coll_cnt");
    chk(A_STS, st(1'b1), 1'b1, "coll_first_pend");
    wr(A_ACK, 4'hF, 32'd1);
    acks++;
    wr(A_ACK, 4'hF, 32'd1);
    chk(A_STS, st(1'b1), 1'b1, "coll_pend_wins");
    wr(A_CTRL, 4'hF, 32'h0);
    wr(A_ACK, 4'hF, 32'd1);
    acks++;
    chk(A_STS, st(1'b0), 1'b0, "coll_cleanup");
    wr(A_ACK, 4'hF, 32'd1);
    chk(A_STS, st(1'b0), 1'b0, "ack_no_pend");

    // Byte lanes and decode
    wr(A_PER, 4'hF, 32'h1122_3344);
    wr(A_PER, 4'b0100, 32'h00AA_0000);
    chk(A_PER, 32'h11AA_3344, 1'b0, "lane_merge");
    wr(BASE + 32'h14, 4'hF, 32'hFFFF_FFFF);
    chk(BASE + 32'h14, 32'd0, 1'b0, "outside_read");
    chk(BASE - 32'h4, 32'd0, 1'b0, "below_read");
    chk(A_CTRL, 32'h0, 1'b0, "outside_ctrl_kept");
    chk(A_PER, 32'h11AA_3344, 1'b0, "outside_per_kept");
    wr(A_CNT, 4'hF, 32'h0000_00FF);
    chk(A_CNT, 32'd0, 1'b0, "count_ro");
    chk(A_ACK, 32'd0, 1'b0, "ack_reads0");
    wr(A_STS, 4'hF, 32'hFFFF_FFFF);
    acks = 16'd0;
    chk(A_STS, st(1'b0), 1'b0, "status_write");

    // Reset mid-count
    wr(A_PER, 4'hF, 32'd100);
    wr(A_CTRL, 4'hF, 32'h5);
    idle(19);
    chk(A_CNT, 32'd81, 1'b0, "midcount");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    acks = 16'd0;
    chk(A_CTRL, 32'd0, 1'b0, "mrst_ctrl");
    chk(A_PER,  32'd0, 1'b0, "mrst_period");
    chk(A_CNT,  32'd0, 1'b0, "mrst_count");
    chk(A_STS,  32'd0, 1'b0, "mrst_status");
    idle(110);
    chk(A_STS, 32'd0, 1'b0, "mrst_no_late_irq");

    // Three effective ACKs
    for (int r = 0; r < 3; r++) begin
      wr(A_CTRL, 4'hF, 32'h5);
      idle(2);
      wr(A_ACK, 4'hF, 32'd1);
      acks++;
    end
    chk(A_STS, st(1'b0), 1'b0, "ackcnt3");
    chk(A_CTRL, 32'h4, 1'b0, "ackcnt_ctrl");

    idle(2);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_gen.md
Name: int_gen

Overview:
- Memory-mapped interrupt source that drives the CPU external `interrupt` line and answers the bridge's interrupt-space bus (`m_int_addr` / `m_int_byteen` side) plus register reads.
- Programmable down-counter; raises IRQ on expiry and holds it until software acknowledges it with a bus write.
- Sits beside the two timers on the bridge, in the word window after them.

Parameters:
- BASE_ADDR, 32'h0000_7F20, byte address of register 0; the window is BASE_ADDR to BASE_ADDR+0x13.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  32  bus byte address; bits [1:0] ignored
- byteen  in  4  byte-lane write enables; any nonzero value in the window is a write
- wdata  in  32  write data, lane-aligned
- rdata  out  32  read data, combinational from addr
- IRQ  out  1  interrupt request to CPU HWInt[2]

Behaviour:
- Register map (word offset from BASE_ADDR):
  - 0x0 CTRL: [0] EN, [1] MODE (0 = one-shot, 1 = periodic), [2] IM (IRQ mask, 1 = pass); other bits read 0.
  - 0x4 PERIOD: 32-bit, read/write.
  - 0x8 COUNT: read-only current counter.
  - 0xC STATUS: [0] PEND; other bits 0 unless the optional feature is on.
  - 0x10 ACK: write-only; any write clears PEND; reads 0.
- Writes:
  - hit = addr in window and byteen != 0.
  - Per-byte merge on CTRL and PERIOD: lane i is updated only when byteen[i] = 1.
  - Writes to COUNT and STATUS are ignored.
- Reads: rdata = selected register; 0 outside the window.
- Reset:
  - CTRL, PERIOD, COUNT and PEND are all 0; state is IDLE; IRQ is 0.
  - rdata is therefore 0 for every address.
- FSM transitions:
  - IDLE: a CTRL write that makes EN go 0->1 moves to CNT and loads COUNT <= PERIOD (the new PERIOD value if it is written in the same cycle is not possible; PERIOD is a separate address).
  - CNT: if COUNT == 0, go to PND and set PEND <= 1; otherwise COUNT <= COUNT-1.
  - PND: wait for an ACK write. On ACK:
    - MODE = 1 and EN = 1: go to CNT with COUNT <= PERIOD.
    - otherwise: go to IDLE and clear EN.
  - Any state: a CTRL write with EN = 0 goes to IDLE, holds COUNT, and keeps PEND.
- Latency:
  - Enable write at edge t0 gives PEND = 1 after edge t0+PERIOD+1.
  - PERIOD = 0 gives PEND one edge after enable.
- IRQ:
  - Registered: IRQ <= next_PEND & next_IM.
  - Clearing IM drops IRQ on the next edge while PEND stays set.
- Simultaneous events:
  - Expiry and ACK in the same cycle: the ACK is discarded and PEND becomes 1.
  - ACK while PEND = 0: no effect.
  - A CTRL write with EN = 1 while already in CNT or PND does not restart counting; MODE and IM still update.
  - A PERIOD write while in CNT affects only the next reload.
- COUNT does not wrap: it stops at 0 and the FSM leaves CNT.
- Reset mid-count or mid-pending: immediately returns to the reset state on the edge; there is no deferred IRQ.

Optional Feature:
- Macro: INT_GEN_ACKCNT_EN.
- Defined:
  - STATUS[31:16] counts ACK writes that actually clear PEND.
  - The counter saturates at 16'hFFFF and is reset to 0.
  - Any write to STATUS clears the counter.
- Undefined:
  - STATUS[31:16] reads 0.
  - No counter register exists.

Test Plan:
- One-shot timing: PERIOD = 5, then CTRL = 0x5 at t0 -> IRQ = 1 after edge t0+6. Then ACK -> IRQ = 0 next edge, state IDLE, CTRL reads 0x4.
- Periodic mode: PERIOD = 3, CTRL = 0x7 -> IRQ rises 4 edges after enable. ACK at k -> IRQ falls at k+1 and rises again at k+1+4. Repeat 3 times.
- Masking: CTRL = 0x1, PERIOD = 0 -> STATUS reads 0x1 and IRQ stays 0. Then write CTRL byteen = 4'b0001, wdata = 0x5 -> IRQ = 1 next edge.
- Collision: arrange ACK on the same edge COUNT reaches 0 in periodic mode -> PEND = 1 and IRQ stays or goes high.
- Byte lanes and decode:
  - PERIOD = 0x11223344, then write byteen = 4'b0100 with wdata = 0x00AA0000 -> reads 0x11AA3344.
  - A write to BASE_ADDR+0x14 changes nothing and returns rdata = 0.
- Reset mid-count: PERIOD = 100, enable, assert reset at cycle 20 -> every register reads 0, IRQ = 0. With INT_GEN_ACKCNT_EN defined, 3 effective ACKs -> STATUS = 0x00030000.
